serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/bit_full_adder.sv | 30 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_full_adder.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: IDLE/RUN/DONE FSM time-sharing one full-adder cell, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e          state_q,     state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic            c_q,         c_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            carry_out_q, carry_out_d;

  logic fa_s;
  logic fa_co;

  bit_full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_d  = {fa_s, sum_q[WIDTH-1:1]};
        c_d    = fa_co;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = DONE;
          carry_out_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB while the MSB is being summed
          ovf_d       = c_q ^ fa_co;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      carry_out_q <= carry_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned last_done_cyc = 0;
  int unsigned prev_done_cyc = 0;
  exp_t        exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y};
    e.sum   = t[WIDTH-1:0];
    e.carry = t[WIDTH];
    e.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding add
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("carry_out", 32'(carry_out), 32'(e.carry));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit expect_result);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    if (expect_result) exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < WIDTH + 4);
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    // 0x3C + 0x05 with cycle-exact busy/done timing
    start_op(8'h3C, 8'h05, 1'b1);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("sum_held", 32'(sum), 32'h41);

    start_op(8'hFF, 8'h01, 1'b1);
    wait_done("ff_01");
    start_op(8'h7F, 8'h01, 1'b1);
    wait_done("7f_01");

    // Start re-asserted mid-RUN with other operands must be ignored
    dc = done_cnt;
    start_op(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'hBB;
    idle_cycles(3);
    start = 1'b0;
    wait_done("ignore_start");
    idle_cycles(3);
    check("ignore_done_count", done_cnt - dc, 32'd1);
    check("ignore_sum_held", 32'(sum), 32'h46);

    // Reset in the 4th RUN cycle aborts without a done pulse
    dc = done_cnt;
    start_op(8'h55, 8'h66, 1'b0);
    idle_cycles(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    idle_cycles(WIDTH + 3);
    check("abort_no_done", done_cnt - dc, 32'd0);
    start_op(8'h10, 8'h20, 1'b1);
    wait_done("after_abort");

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);

    // Back-to-back: second start in the IDLE cycle right after DONE
    start_op(8'hC8, 8'h64, 1'b1);
    wait_done("b2b_first");
    start_op(8'h0F, 8'hF0, 1'b1);
    wait_done("b2b_second");
    check("b2b_spacing", last_done_cyc - prev_done_cyc, WIDTH + 2);

    // Random operands
    for (int unsigned i = 0; i < 6; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      wait_done("random");
    end

    idle_cycles(2);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
